// File: rtl/uart_fifo.sv
// UART transmitter and receiver, each buffered by its own FIFO and clocked from
// one shared 16x oversample divider. Frame: start, DATA_BITS LSB first, optional parity, one stop.
module uart_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       write_enable,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_full,
    input  logic       rx,
    output logic       ready,
    input  logic       ready_clr,
    output logic [7:0] data_out,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    input  logic       err_clr
);
    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DMASK   = 8'((9'd1 << DATA_BITS) - 9'd1);
    localparam logic       PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // Oversample divider and TX bit-tick prescaler
    logic [DIV_W-1:0] div_q;
    logic [3:0]       tx_os_q;
    logic             os_tick, bit_tick;

    assign os_tick  = (div_q == DIV_W'(DIV - 1));
    assign bit_tick = os_tick && (tx_os_q == 4'd15);

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            tx_os_q <= '0;
        end else begin
            div_q <= os_tick ? '0 : div_q + 1'b1;
            if (os_tick)
                tx_os_q <= tx_os_q + 4'd1;
        end
    end

    // TX FIFO; pointers carry one extra bit so full and empty differ
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wr_q, tx_rd_q;
    logic        tx_empty, tx_push, tx_pop;
    logic [7:0]  tx_load;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
    assign tx_push  = write_enable && !tx_full;
    assign tx_load  = tx_mem[tx_rd_q[AW-1:0]] & DMASK;

    always_ff @(posedge clk_50mhz) begin
        if (tx_push)
            tx_mem[tx_wr_q[AW-1:0]] <= data_in;
    end

    // TX FSM
    state_t     tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic       tx_par_q, tx_par_d;

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            tx_state_q <= S_IDLE;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_par_q   <= tx_par_d;
            if (tx_push)
                tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)
                tx_rd_q <= tx_rd_q + 1'b1;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        if (bit_tick) begin
            unique case (tx_state_q)
                // STOP falls through to a fresh START so queued frames run gap-free
                S_IDLE, S_STOP: begin
                    tx_state_d = S_IDLE;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_load;
                        tx_par_d   = (^tx_load) ^ PAR_ODD;
                        tx_bit_d   = '0;
                        tx_state_d = S_START;
                    end
                end
                S_START:  tx_state_d = S_DATA;
                S_DATA: begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'(DATA_BITS - 1))
                        tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: tx_state_d = S_STOP;
                default:  tx_state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (tx_state_q)
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_shift_q[0];
            S_PARITY: tx = tx_par_q;
            default:  tx = 1'b1;
        endcase
    end

    assign tx_busy = !tx_empty || (tx_state_q != S_IDLE);

    // RX synchroniser plus one more stage for falling-edge detection
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX FIFO
    logic [7:0]  rx_mem [FIFO_DEPTH];
    logic [AW:0] rx_wr_q, rx_rd_q;
    logic        rx_empty, rx_full, rx_push, rx_pop;
    logic [7:0]  rx_head;

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
    assign rx_pop   = ready_clr && !rx_empty;
    assign rx_head  = rx_mem[rx_rd_q[AW-1:0]];
    assign ready    = !rx_empty;

    // RX FSM
    state_t     rx_state_q, rx_state_d;
    logic [3:0] rx_os_q, rx_os_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic       rx_par_q, rx_par_d;
    logic       rx_par_bad, set_frame, set_parity, set_overrun;
    logic       frame_err_q, parity_err_q, overrun_q;

    assign rx_par_bad = (PARITY != 0) && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));

    always_ff @(posedge clk_50mhz) begin
        if (rx_push)
            rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
    end

    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            rx_state_q   <= S_IDLE;
            rx_os_q      <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_par_q     <= 1'b0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            if (rx_push)
                rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)
                rx_rd_q <= rx_rd_q + 1'b1;
            // A new event wins over a simultaneous clear
            frame_err_q  <= (frame_err_q  && !err_clr) || set_frame;
            parity_err_q <= (parity_err_q && !err_clr) || set_parity;
            overrun_q    <= (overrun_q    && !err_clr) || set_overrun;
        end
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_os_d     = rx_os_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_d    = rx_par_q;
        rx_push     = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
        set_overrun = 1'b0;
        unique case (rx_state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = S_START;
                    rx_os_d    = '0;
                end
            end
            S_START: begin
                if (os_tick) begin
                    rx_os_d = rx_os_q + 4'd1;
                    // Mid start bit; from here every 16th tick lands mid-bit
                    if (rx_os_q == 4'd8) begin
                        rx_os_d = '0;
                        if (rx_sync_q) begin
                            rx_state_d = S_IDLE;
                        end else begin
                            rx_state_d = S_DATA;
                            rx_bit_d   = '0;
                            rx_shift_d = '0;
                        end
                    end
                end
            end
            default: begin
                if (os_tick) begin
                    rx_os_d = rx_os_q + 4'd1;
                    if (rx_os_q == 4'd15) begin
                        if (rx_state_q == S_DATA) begin
                            rx_shift_d[rx_bit_q] = rx_sync_q;
                            rx_bit_d = rx_bit_q + 3'd1;
                            if (rx_bit_q == 3'(DATA_BITS - 1))
                                rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                        end else if (rx_state_q == S_PARITY) begin
                            rx_par_d   = rx_sync_q;
                            rx_state_d = S_STOP;
                        end else begin
                            rx_state_d = S_IDLE;
                            if (!rx_sync_q)
                                set_frame = 1'b1;
                            else if (rx_par_bad)
                                set_parity = 1'b1;
                            else if (rx_full)
                                set_overrun = 1'b1;
                            else
                                rx_push = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dout
            if (gi < DATA_BITS) begin : g_live
                assign data_out[gi] = ready && rx_head[gi];
            end else begin : g_zero
                assign data_out[gi] = 1'b0;
            end
        end
    endgenerate

endmodule

// File: tb/tb_uart_fifo.sv
// Randomised bench for uart_fifo: a default-rate instance (TX, loopback, glitch,
// TX FIFO full/reset) and a fast even-parity instance (RX stream, errors, overrun).
module tb_uart_fifo;
    localparam int BIT0 = 432;
    localparam int BIT2 = 64;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst;
    logic [7:0] din0;
    logic       we0, tx0, busy0, full0, rx0, rdy0, rclr0, fe0, pe0, ov0, eclr0;
    logic [7:0] dout0;
    logic       loop, rx_drv;
    logic       tx2, busy2, full2, rx2, rdy2, rclr2, fe2, pe2, ov2, eclr2;
    logic [7:0] dout2;

    assign rx0 = loop ? tx0 : rx_drv;

    uart_fifo #(.PARITY(0)) dut0 (
        .clk_50mhz(clk), .rst(rst), .data_in(din0), .write_enable(we0),
        .tx(tx0), .tx_busy(busy0), .tx_full(full0), .rx(rx0), .ready(rdy0),
        .ready_clr(rclr0), .data_out(dout0), .frame_err(fe0), .parity_err(pe0),
        .overrun(ov0), .err_clr(eclr0)
    );

    uart_fifo #(.BAUD(781250), .PARITY(2)) dut2 (
        .clk_50mhz(clk), .rst(rst), .data_in(8'h00), .write_enable(1'b0),
        .tx(tx2), .tx_busy(busy2), .tx_full(full2), .rx(rx2), .ready(rdy2),
        .ready_clr(rclr2), .data_out(dout2), .frame_err(fe2), .parity_err(pe2),
        .overrun(ov2), .err_clr(eclr2)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write0(input logic [7:0] d);
        we0  = 1'b1;
        din0 = d;
        tick(1);
        we0  = 1'b0;
    endtask

    task automatic drive_bit(input int tgt, input logic v, input int len);
        if (tgt == 0) rx_drv = v;
        else          rx2    = v;
        tick(len);
    endtask

    // Serialise one frame; dut2 expects even parity, par_ok=0 inverts it
    task automatic send_frame(input int tgt, input logic [7:0] d, input bit par_ok, input bit stop_ok);
        int len;
        len = (tgt == 0) ? BIT0 : BIT2;
        drive_bit(tgt, 1'b0, len);
        for (int i = 0; i < 8; i++) drive_bit(tgt, d[i], len);
        if (tgt == 2) drive_bit(tgt, (^d) ^ !par_ok, len);
        drive_bit(tgt, stop_ok, len);
        drive_bit(tgt, 1'b1, len);
    endtask

    // Reference model of dut2's receive side
    logic [7:0] q2[$];
    logic       m_fe, m_pe, m_ov;
    logic [7:0] q0[$];

    task automatic model_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
        if (!stop_ok)             m_fe = 1'b1;
        else if (!par_ok)         m_pe = 1'b1;
        else if (q2.size() == 16) m_ov = 1'b1;
        else                      q2.push_back(d);
    endtask

    task automatic check_rx2(input string tag);
        check({tag, ".ready"}, rdy2, q2.size() != 0);
        check({tag, ".data"}, dout2, (q2.size() != 0) ? q2[0] : 8'h00);
        check({tag, ".frame_err"}, fe2, m_fe);
        check({tag, ".parity_err"}, pe2, m_pe);
        check({tag, ".overrun"}, ov2, m_ov);
    endtask

    task automatic pop2(input string tag);
        check({tag, ".pop_ready"}, rdy2, 1);
        check({tag, ".pop_data"}, dout2, q2[0]);
        rclr2 = 1'b1;
        tick(1);
        rclr2 = 1'b0;
        void'(q2.pop_front());
    endtask

    task automatic pop0(input string tag);
        check({tag, ".pop_ready"}, rdy0, 1);
        check({tag, ".pop_data"}, dout0, q0[0]);
        rclr0 = 1'b1;
        tick(1);
        rclr0 = 1'b0;
        void'(q0.pop_front());
    endtask

    task automatic loop_drain(input string tag);
        int t;
        t = 0;
        while (busy0 === 1'b1 && t < 40000) begin
            tick(1);
            t++;
        end
        check({tag, ".tx_drained"}, busy0, 0);
        tick(500);
        while (q0.size() != 0) pop0(tag);
        check({tag, ".ready_after"}, rdy0, 0);
        check({tag, ".flags"}, {fe0, pe0, ov0}, 3'b000);
    endtask

    logic [7:0] d;
    logic [7:0] exp55;
    int         t, k, n, lows;
    bit         par_ok, stop_ok;

    initial begin
        rst = 1'b1; din0 = '0; we0 = 1'b0; rclr0 = 1'b0; eclr0 = 1'b0;
        loop = 1'b0; rx_drv = 1'b1; rx2 = 1'b1; rclr2 = 1'b0; eclr2 = 1'b0;
        m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
        tick(3);

        check("rst.tx", tx0, 1);
        check("rst.tx_busy", busy0, 0);
        check("rst.tx_full", full0, 0);
        check("rst.ready", rdy0, 0);
        check("rst.data_out", dout0, 0);
        check("rst.flags", {fe0, pe0, ov0}, 3'b000);
        check("rst.tx2", tx2, 1);
        check("rst.ready2", rdy2, 0);
        rst = 1'b0;
        tick(5);

        // Even-parity frame of 0x07 with parity bit 0 is rejected
        send_frame(2, 8'h07, 1'b0, 1'b1);
        model_frame(8'h07, 1'b0, 1'b1);
        $display("rx2 directed frame data=07 parity bit 0");
        check_rx2("par07");
        eclr2 = 1'b1; tick(1); eclr2 = 1'b0;
        m_pe = 1'b0;
        check("par07.cleared", pe2, 0);

        // Single 0x55 frame, bit timing and busy
        check("tx55.idle", tx0, 1);
        write0(8'h55);
        $display("tx0 write 55");
        t = 0;
        while (tx0 !== 1'b0 && t < 2000) begin tick(1); t++; end
        check("tx55.start_seen", tx0, 0);
        t = 0;
        while (tx0 === 1'b0 && t < 1000) begin tick(1); t++; end
        check("tx55.start_len", t, BIT0);
        tick(BIT0 / 2);
        exp55 = 8'h55;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx55.bit%0d", i), tx0, exp55[i]);
            tick(BIT0);
        end
        check("tx55.stop", tx0, 1);
        check("tx55.busy_in_stop", busy0, 1);
        tick(BIT0);
        check("tx55.busy_after", busy0, 0);
        check("tx55.idle_after", tx0, 1);

        // Loopback: fixed back-to-back bytes, then a random burst
        loop = 1'b1;
        tick(10);
        write0(8'hA3); write0(8'h00); write0(8'hFF);
        q0.push_back(8'hA3); q0.push_back(8'h00); q0.push_back(8'hFF);
        $display("tx0 loopback write A3 00 FF");
        loop_drain("loop_fixed");
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            write0(d);
            q0.push_back(d);
            $display("tx0 loopback write %02h", d);
        end
        loop_drain("loop_rand");
        loop = 1'b0;

        // 200-clock glitch is a false start
        rx_drv = 1'b0; tick(200); rx_drv = 1'b1;
        $display("rx0 glitch 200 clocks");
        tick(4600);
        check("glitch.ready", rdy0, 0);
        check("glitch.flags", {fe0, pe0, ov0}, 3'b000);

        // Random RX stream with occasional framing/parity errors
        for (int f = 0; f < 24; f++) begin
            d = 8'($urandom);
            k = $urandom_range(0, 7);
            stop_ok = (k != 0);
            par_ok  = (k != 1);
            send_frame(2, d, par_ok, stop_ok);
            model_frame(d, par_ok, stop_ok);
            $display("rx2 frame %0d data=%02h par_ok=%0d stop_ok=%0d", f, d, par_ok, stop_ok);
            check_rx2($sformatf("rnd%0d", f));
            if ($urandom_range(0, 1) == 1 && q2.size() != 0) pop2($sformatf("rnd%0d", f));
            if ($urandom_range(0, 3) == 0) begin
                eclr2 = 1'b1; tick(1); eclr2 = 1'b0;
                m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
                check($sformatf("rnd%0d.clr", f), {fe2, pe2, ov2}, 3'b000);
            end
        end

        // Overrun: FIFO_DEPTH+1 frames with no pops
        rst = 1'b1; tick(2); rst = 1'b0;
        q2.delete(); m_fe = 1'b0; m_pe = 1'b0; m_ov = 1'b0;
        tick(5);
        for (int f = 0; f < 17; f++) begin
            d = 8'($urandom);
            send_frame(2, d, 1'b1, 1'b1);
            model_frame(d, 1'b1, 1'b1);
            $display("rx2 fill frame %0d data=%02h", f, d);
        end
        check_rx2("ovr");
        n = 0;
        while (q2.size() != 0 && n < 16) begin
            pop2($sformatf("ovr%0d", n));
            n++;
        end
        check("ovr.popped", n, 16);
        check("ovr.empty", rdy2, 0);

        // TX FIFO full: 16 writes fill it before the first bit tick after reset
        rst = 1'b1; tick(2); rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            write0(8'(i * 13 + 1));
            if (i == 14) check("txfull.at15", full0, 0);
        end
        check("txfull.at16", full0, 1);
        write0(8'hEE);
        $display("tx0 17th write dropped");
        check("txfull.at17", full0, 1);
        t = 0;
        while (tx0 !== 1'b0 && t < 1000) begin tick(1); t++; end
        check("txfull.start_seen", tx0, 0);
        check("txfull.after_pop", full0, 0);
        tick(300);
        #3 rst = 1'b1;
        #1;
        check("midrst.tx", tx0, 1);
        check("midrst.tx_busy", busy0, 0);
        check("midrst.tx_full", full0, 0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        repeat (1000) begin
            tick(1);
            if (tx0 !== 1'b1) lows++;
        end
        check("midrst.tx_low_clocks", lows, 0);
        check("midrst.busy_after", busy0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_fifo.md
UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, word length; legal values 5..8.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, entries per TX and RX FIFO; power of two, at least 2.
REQ-006 SHALL have port clk_50mhz, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port data_in, input, 8 bits: TX byte; bits above DATA_BITS-1 ignored.
REQ-009 SHALL have port write_enable, input, 1 bit: push data_in into TX FIFO.
REQ-010 SHALL have port tx, output, 1 bit: serial out, idle high.
REQ-011 SHALL have port tx_busy, output, 1 bit: TX FIFO non-empty or frame in progress.
REQ-012 SHALL have port tx_full, output, 1 bit: TX FIFO full.
REQ-013 SHALL have port rx, input, 1 bit: asynchronous serial in.
REQ-014 SHALL have port ready, output, 1 bit: RX FIFO non-empty.
REQ-015 SHALL have port ready_clr, input, 1 bit: pop RX FIFO head.
REQ-016 SHALL have port data_out, output, 8 bits: RX FIFO head, zero-extended above DATA_BITS.
REQ-017 SHALL have ports frame_err, parity_err and overrun, outputs, 1 bit each: sticky error flags.
REQ-018 SHALL have port err_clr, input, 1 bit: clears all three error flags.

Function
REQ-019 SHALL generate a 16x oversample tick, one cycle wide, every DIV = CLK_HZ/(BAUD*16) clocks (integer floor); the TX bit tick is every 16th oversample tick.
REQ-020 SHALL push to the TX FIFO on write_enable && !tx_full; a write while full SHALL be dropped with no other side effect.
REQ-021 The TX FSM SHALL cycle IDLE -> START -> DATA -> PARITY (only if PARITY != 0) -> STOP -> IDLE, each state lasting one bit tick.
REQ-022 The TX FSM SHALL leave IDLE at the first bit tick at which the FIFO is non-empty, popping the FIFO at that tick.
REQ-023 TX SHALL send data LSB first; the parity bit makes the total count of ones odd (PARITY=1) or even (PARITY=2); the stop bit is one bit, high.
REQ-024 Back-to-back frames SHALL have no idle gap: if the FIFO is non-empty at the end of STOP, the next START follows immediately.
REQ-025 SHALL pass rx through a 2-flop synchroniser before any use.
REQ-026 The RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-027 In IDLE, a synchronised high-to-low transition SHALL enter START.
REQ-028 START SHALL sample rx at oversample count 8; if rx is high (false start) the FSM SHALL return to IDLE; otherwise all later bits are sampled every 16 ticks.
REQ-029 At the STOP sample point: if the stop bit is low, SHALL set frame_err and discard the byte.
REQ-030 At the STOP sample point: if parity mismatches, SHALL set parity_err and discard the byte.
REQ-031 At the STOP sample point: if the RX FIFO is full, SHALL set overrun and discard the byte.
REQ-032 At the STOP sample point with no error, SHALL push the byte; the FSM then returns to IDLE.
REQ-033 ready_clr while ready SHALL pop the head on that clock; ready_clr while empty SHALL be ignored.
REQ-034 A push and a pop in the same cycle on either FIFO SHALL both take effect, with occupancy unchanged.
REQ-035 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 Full/empty SHALL be distinguished with an extra pointer bit or a count.
REQ-037 When err_clr and a new error event occur in the same cycle, the flag SHALL end set.

Reset
REQ-038 rst SHALL asynchronously force: tx=1, tx_busy=0, tx_full=0, ready=0, data_out=0, all error flags 0.
REQ-039 rst SHALL also force: both FIFOs empty, both FSMs to IDLE, divider and oversample counters to 0.
REQ-040 A reset asserted mid-frame SHALL abort the frame; after rst deasserts, tx SHALL stay high until new data is written.

Verification (CLK_HZ=50000000, BAUD=115200 -> DIV=27, bit = 432 clocks)
REQ-041 Write 0x55, PARITY=0 -> tx low for 432 clocks, then 1,0,1,0,1,0,1,0, then high for 432 clocks; tx_busy falls after the stop bit.
REQ-042 Loop tx to rx and write 0xA3, 0x00, 0xFF back-to-back -> ready asserts; three ready_clr pops return 0xA3, 0x00, 0xFF; no error flags set.
REQ-043 PARITY=2: drive a frame carrying 0x07 with parity bit 0 -> parity_err=1, ready stays 0; err_clr -> parity_err=0.
REQ-044 Drive a 200-clock low glitch on rx -> no byte is pushed and no flag is set; drive a frame whose stop bit is low -> frame_err=1.
REQ-045 Receive FIFO_DEPTH+1 frames with no pops -> ready=1, the FIFO holds the first 16 bytes, and overrun=1.
REQ-046 Write 17 bytes while TX is idle -> tx_full=1 after 16 writes and the 17th write is dropped; assert rst mid-frame -> tx=1 and tx_busy=0 immediately.
